// File: rtl/display_scanner_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner:
// glyph codes used by the error banner, the blank segment pattern and
// a helper that maps a digit position to its "Erro" banner code.
package display_scanner_pkg;

  // Codes reused as letters in the "Erro" banner.
  localparam logic [3:0] GLYPH_E    = 4'hC;
  localparam logic [3:0] GLYPH_R    = 4'hE;
  localparam logic [3:0] GLYPH_O    = 4'hF;
  // Any of A, B or D decodes to an unlit digit.
  localparam logic [3:0] CODE_BLANK = 4'hA;

  // Active-low abcdefg with every segment dark.
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  // Banner code for a digit position: "Erro" on digits 3..0, blank above.
  function automatic logic [3:0] error_code(input int unsigned idx);
    case (idx)
      0:       error_code = GLYPH_O;
      1, 2:    error_code = GLYPH_R;
      3:       error_code = GLYPH_E;
      default: error_code = CODE_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/display_scanner_seg_glyph.sv
// Combinational 4-bit code to active-low {a,b,c,d,e,f,g} decoder.
module seg_glyph
  import display_scanner_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] segments
);

  // Decode one code to its segment pattern.
  always_comb begin
    // NOTE: default assignment first so every path drives segments; no latch.
    segments = SEG_BLANK;
    case (code)
      4'h0: segments = 7'b0000001;
      4'h1: segments = 7'b1001111;
      4'h2: segments = 7'b0010010;
      4'h3: segments = 7'b0000110;
      4'h4: segments = 7'b1001100;
      4'h5: segments = 7'b0100100;
      4'h6: segments = 7'b0100000;
      4'h7: segments = 7'b0001111;
      4'h8: segments = 7'b0000000;
      4'h9: segments = 7'b0000100;
      4'hC: segments = 7'b0110000;
      4'hE: segments = 7'b1111010;
      4'hF: segments = 7'b1100010;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment driver. Holds a shadow copy of
// the digit codes, steps one digit per SCAN_DIV clocks, and applies
// leading-zero blanking, the "Erro" banner and whole-display blink before
// registering the segment and digit-enable pins.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic                  error,
  input  logic                  blink_enable,
  input  logic                  blank_leading,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_select,
  output logic                  frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0]     LAST_INDEX = IW'(DIGITS - 1);
  localparam logic [PW-1:0]     LAST_COUNT = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0]     LAST_FRAME = FW'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] FIRST_HOT  = DIGITS'(1);

  logic [4*DIGITS-1:0] shadow;
  logic [PW-1:0]       prescaler;
  logic [IW-1:0]       index;
  logic [FW-1:0]       frame_count;
  logic                blink_phase;

  logic                slot_end;
  logic                frame_wrap;
  logic [DIGITS-1:0]   zero_run;
  logic [3:0]          digit_code;
  logic                blank_digit;
  logic [3:0]          shown_code;
  logic [6:0]          glyph_segments;

  assign slot_end   = (prescaler == LAST_COUNT);
  assign frame_wrap = slot_end && (index == LAST_INDEX);

  // Capture the digit codes whenever load is high.
  always_ff @(posedge clock) begin
    // NOTE: shadow is plain flops, not a RAM, so resetting it is cheap and
    // gives a defined all-zero display after reset.
    if (reset) shadow <= '0;
    else if (load) shadow <= data;
  end

  // Prescaler and digit index; frame_done marks the index wrap to 0.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking updates so every flop samples pre-edge values.
    if (reset) begin
      prescaler  <= '0;
      index      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (slot_end) begin
        prescaler <= '0;
        index     <= (index == LAST_INDEX) ? '0 : index + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Frame counter and blink phase, stepped on the edge that raises frame_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (frame_count == LAST_FRAME) begin
        frame_count <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

  // zero_run[i] is set when digits DIGITS-1 down to i are all zero.
  always_comb begin
    zero_run = '0;
    zero_run[DIGITS-1] = (shadow[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_run[i] = zero_run[i+1] && (shadow[4*i +: 4] == 4'h0);
    end
  end

  // Choose the code for the digit currently being scanned.
  always_comb begin
    digit_code  = shadow[{index, 2'b00} +: 4];
    blank_digit = blank_leading && (index != '0) && zero_run[index];
    if (error)            shown_code = error_code(int'(index));
    else if (blank_digit) shown_code = CODE_BLANK;
    else                  shown_code = digit_code;
  end

  seg_glyph u_seg_glyph (
    .code     (shown_code),
    .segments (glyph_segments)
  );

  // Register the pins; the blink off phase darkens everything.
  always_ff @(posedge clock) begin
    if (reset || (blink_enable && blink_phase)) begin
      segments     <= SEG_BLANK;
      digit_select <= '1;
    end else begin
      segments     <= glyph_segments;
      digit_select <= ~(FIRST_HOT << index);
    end
  end

endmodule
